// File: rtl/uart_board_sender.sv
// uart_board_sender
//   Streams a snapshot of a packed sudoku board to a byte-wide UART as one
//   ASCII frame: HEADER, one character per cell (cell 0 first), optional
//   checksum, TERM. Drives the UART tx_data/tx_start/tx_busy handshake.
//
// Optional feature: define UART_BOARD_SENDER_CHECKSUM_EN to insert a raw
//   XOR checksum byte (HEADER ^ all cell characters) just before TERM.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   start     in   frame request, sampled only in IDLE
//   board     in   packed board, cell k = board[4k+3:4k]
//   busy      out  frame in progress (LOAD .. WAIT_DONE)
//   done      out  one-cycle pulse after the terminator has gone out
//   tx_data   out  byte to the UART, held while the byte is pending
//   tx_start  out  one-cycle send request to the UART
//   tx_busy   in   UART busy flag
module uart_board_sender #(
    parameter int          CELLS  = 81,
    parameter logic [7:0]  HEADER = 8'h53,
    parameter logic [7:0]  TERM   = 8'h0A
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*CELLS-1:0]   board,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy
);

    localparam int IW = $clog2(CELLS + 3);
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
    localparam int LAST = CELLS + 2;
`else
    localparam int LAST = CELLS + 1;
`endif
    localparam logic [IW-1:0] LAST_IDX  = IW'(LAST);
    localparam logic [IW-1:0] CELLS_IDX = IW'(CELLS);

    typedef enum logic [2:0] {
        IDLE, LOAD, PULSE, WAIT_ACK, WAIT_DONE, FINISH
    } state_t;

    state_t                 state, state_nxt;
    logic [CELLS-1:0][3:0]  shadow;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          cell_idx;
    logic [7:0]             byte_sel;
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
    logic [7:0]             chk;
`endif

    function automatic logic [7:0] enc(input logic [3:0] v);
        if (v == 4'd0)      return 8'h2E;
        else if (v <= 4'd9) return 8'h30 + {4'h0, v};
        else                return 8'h3F;
    endfunction

    // Frame index 0 is the header, 1..CELLS are cells 0..CELLS-1.
    assign cell_idx = idx - 1'b1;

    always_comb begin
        byte_sel = TERM;
        if (idx == '0)
            byte_sel = HEADER;
        else if (idx <= CELLS_IDX)
            byte_sel = enc(shadow[cell_idx]);
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
        else if (idx == IW'(CELLS + 1))
            byte_sel = chk;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        tx_start  = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = PULSE;
            end
            PULSE: begin
                busy      = 1'b1;
                tx_start  = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (!tx_busy) state_nxt = (idx == LAST_IDX) ? FINISH : LOAD;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: snapshot on accept, latch byte in LOAD, advance after each
    // non-terminator byte completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            idx     <= '0;
            tx_data <= 8'h00;
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
            chk     <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    shadow <= board;
                    idx    <= '0;
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
                    chk    <= 8'h00;
`endif
                end
                LOAD: tx_data <= byte_sel;
                WAIT_DONE: if (!tx_busy && idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
`ifdef UART_BOARD_SENDER_CHECKSUM_EN
                    chk <= chk ^ tx_data;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
